// File: rtl/calcu_mc_core_if.sv
// Memory-side handshake bundle for calcu_mc_core: one outstanding req/ack
// transaction at a time, request fields held stable until acknowledged.
interface calcu_mc_core_if #(
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 26
);
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic [INSTR_W-1:0] mem_rdata;
  logic               mem_ack;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ack
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ack
  );
endinterface

// File: rtl/calcu_mc_core.sv
// Multi-cycle Calcu core: FETCH -> EXEC [-> MEM] with an external unified
// memory behind a req/ack handshake that tolerates arbitrary wait states.
module calcu_mc_core #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 16,
  parameter int                NREGS    = 8,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  calcu_mc_core_if.master   bus,
  output logic              retire,
  output logic              halted,
  output logic [ADDR_W-1:0] dbg_pc
);
  localparam int RSW     = $clog2(NREGS);
  localparam int INSTR_W = 4 + 2*RSW + DATA_W;
  localparam int SHW     = $clog2(DATA_W);

  typedef enum logic [3:0] {
    OP_NOP, OP_ADD, OP_ADDI, OP_JMP, OP_JEQ, OP_STORE, OP_LOAD, OP_XOR,
    OP_AND, OP_SUB, OP_OR,   OP_JNE, OP_SHL, OP_SHR,   OP_JLT,  OP_HALT
  } op_e;

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_HALT} state_e;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [INSTR_W-1:0] r_ir;
  logic [DATA_W-1:0]  r_regs [NREGS];
  logic               r_mem_req;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [INSTR_W-1:0] r_mem_wdata;
  logic               r_retire;
  logic               r_halted;

  op_e                w_op;
  op_e                w_fetch_op;
  logic [RSW-1:0]     w_rd;
  logic [RSW-1:0]     w_rs;
  logic [RSW-1:0]     w_rt;
  logic [DATA_W-1:0]  w_imm;
  logic [DATA_W-1:0]  w_rd_val;
  logic [DATA_W-1:0]  w_rs_val;
  logic [DATA_W-1:0]  w_rt_val;
  logic [DATA_W-1:0]  w_ea_full;
  logic [ADDR_W-1:0]  w_ea;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [DATA_W-1:0]  w_alu;
  logic               w_wr_en;
  logic               w_take;
  logic               w_is_mem;

  // rt deliberately aliases the top bits of imm.
  assign w_op       = op_e'(r_ir[INSTR_W-1 -: 4]);
  assign w_fetch_op = op_e'(bus.mem_rdata[INSTR_W-1 -: 4]);
  assign w_rd       = r_ir[INSTR_W-5 -: RSW];
  assign w_rs       = r_ir[INSTR_W-5-RSW -: RSW];
  assign w_imm      = r_ir[DATA_W-1:0];
  assign w_rt       = w_imm[DATA_W-1 -: RSW];
  assign w_rd_val   = r_regs[w_rd];
  assign w_rs_val   = r_regs[w_rs];
  assign w_rt_val   = r_regs[w_rt];
  assign w_ea_full  = w_imm + w_rs_val;
  assign w_ea       = w_ea_full[ADDR_W-1:0];
  assign w_next_pc  = w_take ? w_imm[ADDR_W-1:0] : r_pc;
  assign w_is_mem   = (w_op == OP_STORE) || (w_op == OP_LOAD);

  // NOTE: every variable gets a default before the case, so no op path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    w_alu   = '0;
    w_wr_en = 1'b0;
    w_take  = 1'b0;
    case (w_op)
      OP_ADD:  begin w_alu = w_rs_val + w_rt_val;              w_wr_en = 1'b1; end
      OP_ADDI: begin w_alu = w_rs_val + w_imm;                 w_wr_en = 1'b1; end
      OP_SUB:  begin w_alu = w_rs_val - w_rt_val;              w_wr_en = 1'b1; end
      OP_XOR:  begin w_alu = w_rs_val ^ w_rt_val;              w_wr_en = 1'b1; end
      OP_AND:  begin w_alu = w_rs_val & w_rt_val;              w_wr_en = 1'b1; end
      OP_OR:   begin w_alu = w_rs_val | w_rt_val;              w_wr_en = 1'b1; end
      OP_SHL:  begin w_alu = w_rs_val << w_rt_val[SHW-1:0];    w_wr_en = 1'b1; end
      OP_SHR:  begin w_alu = w_rs_val >> w_rt_val[SHW-1:0];    w_wr_en = 1'b1; end
      OP_JMP:  w_take = 1'b1;
      OP_JEQ:  w_take = (w_rd_val == w_rs_val);
      OP_JNE:  w_take = (w_rd_val != w_rs_val);
      OP_JLT:  w_take = (w_rd_val <  w_rs_val);
      default: ;
    endcase
  end

  // NOTE: all state updates are non-blocking, so every read in this block
  // sees pre-edge values -- that is what makes ADD r1,r1,r1 double r1.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_ir        <= '0;
      // NOTE: the register file is cleared explicitly because programs rely
      // on zeroed registers; a resettable array maps to flops, not a RAM.
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
    end else begin
      r_retire <= 1'b0;
      case (r_state)
        S_FETCH: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (bus.mem_ack) begin
            r_ir      <= bus.mem_rdata;
            r_pc      <= r_pc + ADDR_W'(1);
            r_mem_req <= 1'b0;
            // Register-only ops (HALT included) retire during their EXEC cycle.
            r_retire  <= !((w_fetch_op == OP_STORE) || (w_fetch_op == OP_LOAD));
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_wr_en) r_regs[w_rd] <= w_alu;
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= (w_op == OP_STORE);
            r_mem_addr  <= w_ea;
            r_mem_wdata <= {{(INSTR_W-DATA_W){1'b0}}, w_rd_val};
            r_state     <= S_MEM;
          end else if (w_op == OP_HALT) begin
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            // Launch the next fetch straight from EXEC to keep ALU ops at 2 cycles.
            r_pc       <= w_next_pc;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= w_next_pc;
            r_state    <= S_FETCH;
          end
        end
        S_MEM: begin
          if (bus.mem_ack) begin
            if (!r_mem_we) r_regs[w_rd] <= bus.mem_rdata[DATA_W-1:0];
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

  // Memory ops retire in the acknowledge cycle itself, which only the ack reveals.
  assign retire = r_retire | ((r_state == S_MEM) && r_mem_req && bus.mem_ack);
  assign halted = r_halted;
  assign dbg_pc = r_pc;
endmodule

// File: tb/tb_calcu_mc_core.sv
// Directed bench for calcu_mc_core: a behavioural unified memory with
// programmable wait states, plus one task per feature.
module tb_calcu_mc_core;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 26;

  localparam logic [3:0] NOP = 4'h0, ADD = 4'h1, ADDI = 4'h2, JMP = 4'h3,
                         JEQ = 4'h4, STORE = 4'h5, LOAD = 4'h6, XOR = 4'h7,
                         AND = 4'h8, SUB = 4'h9, OR = 4'hA, JNE = 4'hB,
                         SHL = 4'hC, SHR = 4'hD, JLT = 4'hE, HALT = 4'hF;
  localparam logic [INSTR_W-1:0] POISON = 26'h3FF_FFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  calcu_mc_core_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus();
  logic              retire;
  logic              halted;
  logic [ADDR_W-1:0] dbg_pc;

  calcu_mc_core dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .retire (retire),
    .halted (halted),
    .dbg_pc (dbg_pc)
  );

  int checks = 0;
  int errors = 0;

  logic [INSTR_W-1:0] mem [0:65535];
  logic [INSTR_W-1:0] prog [$];
  logic [ADDR_W-1:0]  rd_log [$];
  logic [ADDR_W-1:0]  wr_addr_log [$];
  logic [INSTR_W-1:0] wr_data_log [$];
  int   waits = 0;
  int   wcnt = 0;
  bit   stab_en = 1'b0;
  logic p_req = 1'b0, p_ack = 1'b0, p_we = 1'b0;
  logic [ADDR_W-1:0]  p_addr = '0;
  logic [INSTR_W-1:0] p_wdata = '0;

  initial begin
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
  end

  // Memory model: completes on the edge where req&&ack, answers #1 after it.
  always begin
    @(posedge clk);
    if (rst) wcnt = 0;
    else if (bus.mem_req && bus.mem_ack) begin
      if (bus.mem_we) begin
        mem[bus.mem_addr] = bus.mem_wdata;
        wr_addr_log.push_back(bus.mem_addr);
        wr_data_log.push_back(bus.mem_wdata);
      end else rd_log.push_back(bus.mem_addr);
      wcnt = 0;
    end else if (bus.mem_req) wcnt++;
    #1;
    if (stab_en && bus.mem_req && p_req && !p_ack) begin
      checks++;
      if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {p_we, p_addr, p_wdata}) begin
        errors++;
        $display("FAIL req_stable: got we=%b addr=%h wdata=%h, held we=%b addr=%h wdata=%h",
                 bus.mem_we, bus.mem_addr, bus.mem_wdata, p_we, p_addr, p_wdata);
      end
    end
    bus.mem_ack   = bus.mem_req && (wcnt >= waits);
    bus.mem_rdata = bus.mem_ack ? mem[bus.mem_addr] : '0;
    p_req = bus.mem_req; p_ack = bus.mem_ack; p_we = bus.mem_we;
    p_addr = bus.mem_addr; p_wdata = bus.mem_wdata;
  end

  function automatic logic [INSTR_W-1:0] enc(input logic [3:0] op, input int rd,
                                              input int rs, input logic [15:0] imm);
    logic [2:0] d, s;
    d = rd[2:0];
    s = rs[2:0];
    return {op, d, s, imm};
  endfunction

  function automatic logic [15:0] rt(input int r);
    return 16'(r) << 13;
  endfunction

  task automatic do_reset(input int w);
    rst = 1'b1;
    waits = w;
    stab_en = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 65536; i++) mem[i] = '0;
    rd_log.delete();
    wr_addr_log.delete();
    wr_data_log.delete();
  endtask

  task automatic install(input int base);
    for (int i = 0; i < prog.size(); i++) mem[16'(base + i)] = prog[i];
  endtask

  // Releases reset and counts cycles from the first request until halted.
  task automatic run_prog(input int max_cyc, output int cyc, output int rets, output bit done);
    int first;
    first = -1; cyc = 0; rets = 0; done = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= max_cyc; n++) begin
      @(negedge clk);
      if (first < 0 && bus.mem_req) first = n;
      if (retire) rets++;
      if (halted) begin
        done = 1'b1;
        cyc = n - first;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.mem_req, bus.mem_we, retire, halted} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got req/we/retire/halted=%b required 0000",
               {bus.mem_req, bus.mem_we, retire, halted});
    end
    checks++;
    if (bus.mem_addr !== 16'h0000 || bus.mem_wdata !== 26'h0) begin
      errors++;
      $display("FAIL reset_bus: got addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    checks++;
    if (dbg_pc !== 16'h0000) begin
      errors++;
      $display("FAIL reset_pc: got %h required 0000", dbg_pc);
    end
  endtask

  task automatic load_sub_prog(input bit with_store);
    prog = {enc(ADDI, 1, 0, 16'd5), enc(ADDI, 2, 0, 16'd3), enc(SUB, 3, 1, rt(2))};
    if (with_store) prog.push_back(enc(STORE, 3, 0, 16'h0040));
    prog.push_back(enc(HALT, 0, 0, 16'h0));
    install(0);
  endtask

  task automatic test_sub_prog(input int w, input int exp_cyc);
    int cyc, rets;
    bit done;
    do_reset(w);
    stab_en = (w > 0);
    load_sub_prog(1'b0);
    run_prog(200, cyc, rets, done);
    checks++;
    if (!done) begin errors++; $display("FAIL sub_w%0d_timeout: halted never rose", w); end
    checks++;
    if (cyc !== exp_cyc) begin errors++; $display("FAIL sub_w%0d_cycles: got %0d required %0d", w, cyc, exp_cyc); end
    checks++;
    if (rets !== 4) begin errors++; $display("FAIL sub_w%0d_retire: got %0d required 4", w, rets); end
    checks++;
    if (dbg_pc !== 16'h0004) begin errors++; $display("FAIL sub_w%0d_pc: got %h required 0004", w, dbg_pc); end

    do_reset(w);
    stab_en = (w > 0);
    load_sub_prog(1'b1);
    mem[16'h0040] = POISON;
    run_prog(200, cyc, rets, done);
    checks++;
    if (mem[16'h0040] !== 26'h2) begin errors++; $display("FAIL sub_w%0d_r3: got %h required 2", w, mem[16'h0040]); end
  endtask

  task automatic test_alu_shift;
    int cyc, rets;
    bit done;
    logic [INSTR_W-1:0] exp [7];
    exp = '{26'h0, 26'h10, 26'h1, 26'h20, 26'h8004, 26'h4, 26'h24};
    do_reset(0);
    prog = {enc(ADDI, 1, 0, 16'hFFFF), enc(ADDI, 1, 1, 16'h0001), enc(STORE, 1, 0, 16'h0040),
            enc(ADDI, 1, 0, 16'h0001), enc(ADDI, 4, 0, 16'h0004), enc(SHL, 2, 1, rt(4)),
            enc(STORE, 2, 0, 16'h0041), enc(ADDI, 5, 0, 16'h8000), enc(ADDI, 6, 0, 16'd15),
            enc(SHR, 7, 5, rt(6)), enc(STORE, 7, 0, 16'h0042), enc(ADD, 2, 2, rt(2)),
            enc(XOR, 3, 5, rt(4)), enc(AND, 6, 3, rt(4)), enc(OR, 1, 2, rt(4)),
            enc(STORE, 2, 0, 16'h0043), enc(STORE, 3, 0, 16'h0044), enc(STORE, 6, 0, 16'h0045),
            enc(STORE, 1, 0, 16'h0046), enc(HALT, 0, 0, 16'h0)};
    install(0);
    for (int i = 0; i < 7; i++) mem[16'h0040 + 16'(i)] = POISON;
    run_prog(400, cyc, rets, done);
    checks++;
    if (!done) begin errors++; $display("FAIL alu_timeout: halted never rose"); end
    for (int i = 0; i < 7; i++) begin
      checks++;
      if (mem[16'h0040 + 16'(i)] !== exp[i]) begin
        errors++;
        $display("FAIL alu_result_%0d: got %h required %h", i, mem[16'h0040 + 16'(i)], exp[i]);
      end
    end
  endtask

  task automatic test_store_load;
    int cyc, rets;
    bit done;
    do_reset(0);
    prog = {enc(ADDI, 1, 0, 16'hABCD), enc(ADDI, 2, 0, 16'hFFFF), enc(STORE, 1, 2, 16'h0002),
            enc(LOAD, 3, 2, 16'h0002), enc(STORE, 3, 0, 16'h0040), enc(HALT, 0, 0, 16'h0)};
    install(0);
    mem[16'h0040] = POISON;
    run_prog(200, cyc, rets, done);
    checks++;
    if (wr_addr_log.size() == 0 || wr_addr_log[0] !== 16'h0001) begin
      errors++;
      $display("FAIL store_addr: got %h required 0001", wr_addr_log.size() ? wr_addr_log[0] : 16'hxxxx);
    end
    checks++;
    if (wr_data_log.size() == 0 || wr_data_log[0] !== 26'h000ABCD) begin
      errors++;
      $display("FAIL store_wdata: got %h required 000abcd", wr_data_log.size() ? wr_data_log[0] : 26'hx);
    end
    checks++;
    if (mem[16'h0040] !== 26'h000ABCD) begin errors++; $display("FAIL load_back: got %h required 000abcd", mem[16'h0040]); end
    checks++;
    if (rets !== 6) begin errors++; $display("FAIL load_retire: got %0d required 6", rets); end
  endtask

  task automatic check_reads(input string name, input logic [ADDR_W-1:0] exp [$]);
    int bad;
    bad = -1;
    for (int i = 0; i < exp.size(); i++)
      if (bad < 0 && (i >= rd_log.size() || rd_log[i] !== exp[i])) bad = i;
    if (bad < 0 && rd_log.size() != exp.size()) bad = exp.size();
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s: read #%0d got %h required %h (%0d reads, %0d required)", name, bad,
               bad < rd_log.size() ? rd_log[bad] : 16'hxxxx,
               bad < exp.size() ? exp[bad] : 16'hxxxx, rd_log.size(), exp.size());
    end
  endtask

  task automatic test_branches;
    int cyc, rets;
    bit done;
    do_reset(0);
    prog = {enc(ADDI, 1, 0, 16'h0001), enc(ADDI, 2, 0, 16'h8000), enc(JEQ, 1, 1, 16'd5),
            enc(ADDI, 7, 0, 16'h0BAD), enc(HALT, 0, 0, 16'h0), enc(JEQ, 1, 2, 16'd3),
            enc(JNE, 1, 2, 16'd8), enc(HALT, 0, 0, 16'h0), enc(JLT, 1, 2, 16'd10),
            enc(HALT, 0, 0, 16'h0), enc(JLT, 2, 1, 16'd3), enc(ADDI, 6, 0, 16'h0055),
            enc(STORE, 6, 0, 16'h0040), enc(STORE, 7, 0, 16'h0041), enc(HALT, 0, 0, 16'h0)};
    install(0);
    mem[16'h0040] = POISON;
    mem[16'h0041] = POISON;
    run_prog(200, cyc, rets, done);
    check_reads("branch_path", '{16'd0, 16'd1, 16'd2, 16'd5, 16'd6, 16'd8, 16'd10,
                                 16'd11, 16'd12, 16'd13, 16'd14});
    checks++;
    if (mem[16'h0040] !== 26'h55 || mem[16'h0041] !== 26'h0) begin
      errors++;
      $display("FAIL branch_regs: got %h/%h required 55/0", mem[16'h0040], mem[16'h0041]);
    end
    checks++;
    if (dbg_pc !== 16'd15) begin errors++; $display("FAIL branch_pc: got %h required 000f", dbg_pc); end
  endtask

  task automatic test_jmp_wrap;
    int cyc, rets;
    bit done;
    do_reset(0);
    prog = {enc(ADDI, 1, 1, 16'h0001), enc(ADDI, 2, 0, 16'h0002), enc(JEQ, 1, 2, 16'd5),
            enc(JMP, 0, 0, 16'hFFFF), enc(HALT, 0, 0, 16'h0), enc(STORE, 1, 0, 16'h0040),
            enc(HALT, 0, 0, 16'h0)};
    install(0);
    mem[16'hFFFF] = enc(NOP, 0, 0, 16'h0);
    mem[16'h0040] = POISON;
    run_prog(200, cyc, rets, done);
    check_reads("wrap_path", '{16'd0, 16'd1, 16'd2, 16'd3, 16'hFFFF, 16'd0, 16'd1, 16'd2,
                               16'd5, 16'd6});
    checks++;
    if (mem[16'h0040] !== 26'h2) begin errors++; $display("FAIL wrap_r1: got %h required 2", mem[16'h0040]); end
    checks++;
    if (dbg_pc !== 16'd7) begin errors++; $display("FAIL wrap_pc: got %h required 0007", dbg_pc); end
  endtask

  task automatic test_reset_mid;
    int cyc, rets;
    bit done, seen;
    do_reset(3);
    prog = {enc(ADDI, 1, 0, 16'h0007), enc(LOAD, 2, 0, 16'h0040), enc(HALT, 0, 0, 16'h0)};
    install(0);
    mem[16'h0040] = 26'h1234;
    seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      @(negedge clk);
      seen = bus.mem_req && !bus.mem_we && (bus.mem_addr === 16'h0040);
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL midrst_timeout: LOAD request never issued"); end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.mem_req, retire, halted} !== 3'b000 || dbg_pc !== 16'h0000) begin
      errors++;
      $display("FAIL midrst_state: got req/retire/halted=%b pc=%h required 000 pc=0000",
               {bus.mem_req, retire, halted}, dbg_pc);
    end
    check_reads("midrst_abandon", '{16'd0, 16'd1});
    rd_log.delete();
    waits = 0;
    prog = {enc(STORE, 1, 0, 16'h0041), enc(STORE, 2, 0, 16'h0042), enc(HALT, 0, 0, 16'h0)};
    install(0);
    mem[16'h0041] = POISON;
    mem[16'h0042] = POISON;
    run_prog(200, cyc, rets, done);
    checks++;
    if (mem[16'h0041] !== 26'h0 || mem[16'h0042] !== 26'h0) begin
      errors++;
      $display("FAIL midrst_regs: got r1=%h r2=%h required 0/0", mem[16'h0041], mem[16'h0042]);
    end
    check_reads("midrst_restart", '{16'd0, 16'd1, 16'd2});
  endtask

  initial begin
    test_reset();
    test_sub_prog(0, 8);
    test_sub_prog(3, 20);
    test_alu_shift();
    test_store_load();
    test_branches();
    test_jmp_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
